// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados
//   Two-port arbiter/sequencer in front of the single-port data memory.
//   Port 0 is the CPU load/store path; port 1 is the I/O / loader path.
//   Requests are served one at a time with round-robin tie-breaking.
//   The served port gets its read data and a one-cycle ack.
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   reqN, weN            level request (held until ackN), 1 = write
//   addrN, wdataN        access address / write data, stable while reqN
//   ackN                 one-cycle completion pulse
//   rdataN               last read result for port N, held until its next read
//   gntN                 port N owns the memory (ACCESS..DONE)
//   busy                 sequencer not idle
//   mem_endereco         memory address
//   mem_dado             memory write data
//   mem_LerMemo          memory read strobe
//   mem_EscrMemo         memory write strobe
//   mem_dado_lido        memory read data, valid MEM_LAT cycles after the read strobe
module arbitro_memoria_dados #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_dado,
  output logic              mem_LerMemo,
  output logic              mem_EscrMemo,
  input  logic [DATA_W-1:0] mem_dado_lido
);

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_LAT,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       port_q;      // port currently being served
  logic       last_srv;    // port served most recently (tie-break)
  logic       we_q;
  logic [2:0] cnt;
  logic       grant_valid;
  logic       grant_port;

  // Tie goes to the port that was not served last.
  always_comb begin
    grant_valid = req0 | req1;
    grant_port  = 1'b0;
    if (req0 && req1) begin
      grant_port = ~last_srv;
    end else if (req1) begin
      grant_port = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (grant_valid) state_nx = ACCESS;
      ACCESS:   state_nx = we_q ? DONE : WAIT_LAT;
      WAIT_LAT: if (cnt == 3'd1) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    gnt0         = busy && !port_q;
    gnt1         = busy && port_q;
    mem_EscrMemo = (state == ACCESS) && we_q;
    mem_LerMemo  = (state == ACCESS) && !we_q;
    ack0         = (state == DONE) && !port_q;
    ack1         = (state == DONE) && port_q;
  end

  // Request fields are latched at grant so the memory side is immune to
  // the requester dropping or changing its request mid-access.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_q       <= 1'b0;
      last_srv     <= 1'b1;
      we_q         <= 1'b0;
      cnt          <= '0;
      mem_endereco <= '0;
      mem_dado     <= '0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            port_q       <= grant_port;
            we_q         <= grant_port ? we1 : we0;
            mem_endereco <= grant_port ? addr1 : addr0;
            mem_dado     <= grant_port ? wdata1 : wdata0;
          end
        end
        ACCESS: cnt <= CNT_INIT;
        WAIT_LAT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (port_q) begin
              rdata1 <= mem_dado_lido;
            end else begin
              rdata0 <= mem_dado_lido;
            end
          end
        end
        DONE: last_srv <= port_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
module tb_arbitro_memoria_dados;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT with MEM_LAT = 1
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, gnt0, gnt1, busy;
  logic [7:0] rdata0, rdata1, mem_endereco, mem_dado, mem_dado_lido;
  logic       mem_LerMemo, mem_EscrMemo;

  // DUT with MEM_LAT = 3
  logic       u3_req0, u3_req1, u3_we0, u3_we1;
  logic [7:0] u3_addr0, u3_addr1, u3_wdata0, u3_wdata1;
  logic       u3_ack0, u3_ack1, u3_gnt0, u3_gnt1, u3_busy;
  logic [7:0] u3_rdata0, u3_rdata1, u3_mem_endereco, u3_mem_dado, u3_mem_dado_lido;
  logic       u3_mem_LerMemo, u3_mem_EscrMemo;

  arbitro_memoria_dados #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .mem_endereco(mem_endereco), .mem_dado(mem_dado),
    .mem_LerMemo(mem_LerMemo), .mem_EscrMemo(mem_EscrMemo),
    .mem_dado_lido(mem_dado_lido)
  );

  arbitro_memoria_dados #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0(u3_req0), .req1(u3_req1), .we0(u3_we0), .we1(u3_we1),
    .addr0(u3_addr0), .addr1(u3_addr1), .wdata0(u3_wdata0), .wdata1(u3_wdata1),
    .ack0(u3_ack0), .ack1(u3_ack1), .rdata0(u3_rdata0), .rdata1(u3_rdata1),
    .gnt0(u3_gnt0), .gnt1(u3_gnt1), .busy(u3_busy),
    .mem_endereco(u3_mem_endereco), .mem_dado(u3_mem_dado),
    .mem_LerMemo(u3_mem_LerMemo), .mem_EscrMemo(u3_mem_EscrMemo),
    .mem_dado_lido(u3_mem_dado_lido)
  );

  // Memory models: read data only becomes valid once the required number of
  // cycles has elapsed after the read strobe; before that it reads 0xEE.
  logic [7:0] mem0 [256] = '{default: 8'h00};
  logic [3:0] lcnt0 = '0;
  logic [3:0] lcnt3 = '0;
  always @(posedge clk) begin
    if (mem_EscrMemo) mem0[mem_endereco] <= mem_dado;
    if (mem_LerMemo) lcnt0 <= 4'd1;
    else if (lcnt0 != 4'd0 && lcnt0 != 4'd15) lcnt0 <= lcnt0 + 4'd1;
    if (u3_mem_LerMemo) lcnt3 <= 4'd1;
    else if (lcnt3 != 4'd0 && lcnt3 != 4'd15) lcnt3 <= lcnt3 + 4'd1;
  end
  assign mem_dado_lido    = (lcnt0 >= 4'd1) ? mem0[mem_endereco] : 8'hEE;
  assign u3_mem_dado_lido = (lcnt3 >= 4'd3) ? (u3_mem_endereco ^ 8'h3C) : 8'hEE;

  typedef struct packed {
    logic       port;
    logic       rd;
    logic [7:0] data;
    logic [7:0] cyc;
  } exp_t;

  typedef struct packed {
    logic       port;
    logic [7:0] rdata;
    logic [7:0] cyc;
  } obs_t;

  exp_t       sb[$];
  obs_t       obs[$];
  logic [5:0] trace[$];   // {esc, ler, gnt0, gnt1, ack0, ack1}

  int n_cmp = 0;
  int n_bad = 0;

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; u3_req0 = 1'b0; u3_req1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Steps the u_dut requesters for ncyc cycles after the next (sample) edge.
  // Cycle 1 is the cycle following the sample edge. Records a per-cycle trace
  // and every ack; drops reqN on the cycle after ackN.
  task automatic run(input int ncyc, input int raise1_at, input int reset_at);
    logic d0, d1;
    trace.delete();
    obs.delete();
    @(posedge clk);
    if (raise1_at == 0) begin
      #1 req1 = 1'b1;
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      trace.push_back({mem_EscrMemo, mem_LerMemo, gnt0, gnt1, ack0, ack1});
      if (ack0) obs.push_back('{port: 1'b0, rdata: rdata0, cyc: 8'(c)});
      if (ack1) obs.push_back('{port: 1'b1, rdata: rdata1, cyc: 8'(c)});
      d0 = ack0;
      d1 = ack1;
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      if (d0) req0 = 1'b0;
      if (d1) req1 = 1'b0;
      if (c == raise1_at) req1 = 1'b1;
      if (c == reset_at) begin
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, gnt0, gnt1, busy, mem_LerMemo, mem_EscrMemo} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000000", {ack0, ack1, gnt0, gnt1, busy, mem_LerMemo, mem_EscrMemo});
    end
    n_cmp++;
    if ({rdata0, rdata1} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h/%h want 00/00", rdata0, rdata1);
    end
    n_cmp++;
    if ({mem_endereco, mem_dado} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_mem_bus: got %h/%h want 00/00", mem_endereco, mem_dado);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    exp_t e;
    obs_t o;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 8'hA5;
    sb.push_back('{port: 1'b0, rd: 1'b0, data: 8'h00, cyc: 8'd2});
    run(6, -1, -1);
    for (int c = 1; c <= trace.size(); c++) begin
      n_cmp++;
      if (trace[c-1][5] !== (c == 1) || trace[c-1][4] !== 1'b0 || trace[c-1][2] !== 1'b0) begin
        n_bad++;
        $display("FAIL wr_strobe_c%0d: esc/ler/gnt1 got %b%b%b want %b00", c,
                 trace[c-1][5], trace[c-1][4], trace[c-1][2], (c == 1));
      end
    end
    n_cmp++;
    if (mem0[8'h05] !== 8'hA5) begin
      n_bad++;
      $display("FAIL wr_mem: got %h want a5", mem0[8'h05]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs.size() == 0) begin
        n_bad++;
        $display("FAIL wr_ack: no ack, want port %0d cycle %0d", e.port, e.cyc);
      end else begin
        o = obs.pop_front();
        if (o.port !== e.port || o.cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL wr_ack: got port %0d cycle %0d want port %0d cycle %0d", o.port, o.cyc, e.port, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs.size() != 0) begin
      n_bad++;
      $display("FAIL wr_extra_ack: got %0d extra want 0", obs.size());
    end
  endtask

  task automatic test_read();
    exp_t e;
    obs_t o;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05; wdata1 = 8'h00;
    sb.push_back('{port: 1'b1, rd: 1'b1, data: 8'hA5, cyc: 8'd3});
    run(7, -1, -1);
    for (int c = 1; c <= trace.size(); c++) begin
      n_cmp++;
      if (trace[c-1][4] !== (c == 1) || trace[c-1][5] !== 1'b0 || trace[c-1][3] !== 1'b0) begin
        n_bad++;
        $display("FAIL rd_strobe_c%0d: ler/esc/gnt0 got %b%b%b want %b00", c,
                 trace[c-1][4], trace[c-1][5], trace[c-1][3], (c == 1));
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs.size() == 0) begin
        n_bad++;
        $display("FAIL rd_ack: no ack, want port %0d cycle %0d", e.port, e.cyc);
      end else begin
        o = obs.pop_front();
        if (o.port !== e.port || o.cyc !== e.cyc || o.rdata !== e.data) begin
          n_bad++;
          $display("FAIL rd_ack: got port %0d cycle %0d data %h want port %0d cycle %0d data %h",
                   o.port, o.cyc, o.rdata, e.port, e.cyc, e.data);
        end
      end
    end
    n_cmp++;
    if (rdata1 !== 8'hA5 || rdata0 !== 8'h00) begin
      n_bad++;
      $display("FAIL rd_hold: got rdata1 %h rdata0 %h want a5 00", rdata1, rdata0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    do_reset();
    for (int round = 0; round < 3; round++) begin
      if (round == 0) begin
        sb.push_back('{port: 1'b0, rd: 1'b0, data: 8'h00, cyc: 8'd2});
        sb.push_back('{port: 1'b1, rd: 1'b0, data: 8'h00, cyc: 8'd5});
      end else if (round == 1) begin
        sb.push_back('{port: 1'b0, rd: 1'b0, data: 8'h00, cyc: 8'd2});
      end else begin
        sb.push_back('{port: 1'b1, rd: 1'b0, data: 8'h00, cyc: 8'd2});
        sb.push_back('{port: 1'b0, rd: 1'b0, data: 8'h00, cyc: 8'd5});
      end
      we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h11;
      we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h22;
      req0 = 1'b1;
      req1 = (round != 1);
      run(7, -1, -1);
      for (int c = 1; c <= trace.size(); c++) begin
        n_cmp++;
        if ((trace[c-1][3] & trace[c-1][2]) !== 1'b0 || (trace[c-1][5] & trace[c-1][4]) !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_excl_r%0d_c%0d: trace %b want no gnt/strobe overlap", round, c, trace[c-1]);
        end
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_ack_r%0d: no ack, want port %0d cycle %0d", round, e.port, e.cyc);
        end else begin
          o = obs.pop_front();
          if (o.port !== e.port || o.cyc !== e.cyc) begin
            n_bad++;
            $display("FAIL b2b_ack_r%0d: got port %0d cycle %0d want port %0d cycle %0d",
                     round, o.port, o.cyc, e.port, e.cyc);
          end
        end
      end
      n_cmp++;
      if (obs.size() != 0) begin
        n_bad++;
        $display("FAIL b2b_extra_r%0d: got %0d extra acks want 0", round, obs.size());
      end
    end
    n_cmp++;
    if (mem0[8'h10] !== 8'h11 || mem0[8'h20] !== 8'h22) begin
      n_bad++;
      $display("FAIL b2b_mem: got %h %h want 11 22", mem0[8'h10], mem0[8'h20]);
    end
  endtask

  task automatic test_held_request();
    exp_t e;
    obs_t o;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 8'h5A;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h05; wdata1 = 8'h00;
    sb.push_back('{port: 1'b0, rd: 1'b0, data: 8'h00, cyc: 8'd2});
    sb.push_back('{port: 1'b1, rd: 1'b1, data: 8'h5A, cyc: 8'd6});
    run(10, 0, -1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs.size() == 0) begin
        n_bad++;
        $display("FAIL held_ack: no ack, want port %0d cycle %0d", e.port, e.cyc);
      end else begin
        o = obs.pop_front();
        if (o.port !== e.port || o.cyc !== e.cyc || (e.rd && o.rdata !== e.data)) begin
          n_bad++;
          $display("FAIL held_ack: got port %0d cycle %0d data %h want port %0d cycle %0d data %h",
                   o.port, o.cyc, o.rdata, e.port, e.cyc, e.data);
        end
      end
    end
    n_cmp++;
    if (obs.size() != 0) begin
      n_bad++;
      $display("FAIL held_extra: got %0d extra acks want 0", obs.size());
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    obs_t o;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    run(5, -1, -1);
    n_cmp++;
    if (rdata0 !== 8'h5A) begin
      n_bad++;
      $display("FAIL rst_pre_rdata0: got %h want 5a", rdata0);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    run(6, -1, 1);
    n_cmp++;
    if (obs.size() != 0) begin
      n_bad++;
      $display("FAIL rst_no_ack: got %0d acks want 0", obs.size());
    end
    for (int c = 3; c <= trace.size(); c++) begin
      n_cmp++;
      if (trace[c-1] !== 6'b0) begin
        n_bad++;
        $display("FAIL rst_idle_c%0d: got %b want 000000", c, trace[c-1]);
      end
    end
    n_cmp++;
    if (rdata0 !== 8'h00 || rdata1 !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_clear: got %h %h busy %b want 00 00 0", rdata0, rdata1, busy);
    end
    req1 = 1'b1;
    sb.push_back('{port: 1'b1, rd: 1'b1, data: 8'h11, cyc: 8'd3});
    run(5, -1, -1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs.size() == 0) begin
        n_bad++;
        $display("FAIL rst_after_ack: no ack, want port %0d cycle %0d", e.port, e.cyc);
      end else begin
        o = obs.pop_front();
        if (o.port !== e.port || o.cyc !== e.cyc || o.rdata !== e.data) begin
          n_bad++;
          $display("FAIL rst_after_ack: got port %0d cycle %0d data %h want port %0d cycle %0d data %h",
                   o.port, o.cyc, o.rdata, e.port, e.cyc, e.data);
        end
      end
    end
  endtask

  task automatic test_latency3();
    exp_t e;
    obs_t o;
    obs.delete();
    u3_req0 = 1'b1; u3_we0 = 1'b0; u3_addr0 = 8'h42; u3_wdata0 = 8'h00;
    sb.push_back('{port: 1'b0, rd: 1'b1, data: 8'h7E, cyc: 8'd5});
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (u3_mem_LerMemo !== (c == 1) || u3_mem_EscrMemo !== 1'b0) begin
        n_bad++;
        $display("FAIL lat3_strobe_c%0d: ler/esc got %b%b want %b0", c, u3_mem_LerMemo, u3_mem_EscrMemo, (c == 1));
      end
      if (u3_ack0) obs.push_back('{port: 1'b0, rdata: u3_rdata0, cyc: 8'(c)});
      if (u3_ack1) obs.push_back('{port: 1'b1, rdata: u3_rdata1, cyc: 8'(c)});
      @(posedge clk);
      #1;
      if (u3_ack0) u3_req0 = 1'b0;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (obs.size() == 0) begin
        n_bad++;
        $display("FAIL lat3_ack: no ack, want port %0d cycle %0d", e.port, e.cyc);
      end else begin
        o = obs.pop_front();
        if (o.port !== e.port || o.cyc !== e.cyc || o.rdata !== e.data) begin
          n_bad++;
          $display("FAIL lat3_ack: got port %0d cycle %0d data %h want port %0d cycle %0d data %h",
                   o.port, o.cyc, o.rdata, e.port, e.cyc, e.data);
        end
      end
    end
    n_cmp++;
    if (obs.size() != 0 || u3_rdata1 !== 8'h00) begin
      n_bad++;
      $display("FAIL lat3_extra: got %0d extra acks rdata1 %h want 0 00", obs.size(), u3_rdata1);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    u3_req0 = 1'b0; u3_req1 = 1'b0; u3_we0 = 1'b0; u3_we1 = 1'b0;
    u3_addr0 = '0; u3_addr1 = '0; u3_wdata0 = '0; u3_wdata1 = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_held_request();
    test_reset_midop();
    test_latency3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
